acc_feeder: RTL
===============

# acc_feeder

Input-side buffering stage that sits directly upstream of the accumulator and drives its `in` port. Words arrive on a valid/ready stream and are stored in a small FIFO. The FIFO drains one word per clock into a registered `in` output. When nothing is drained, `in` is driven to zero, so the accumulator's `sum` holds; no enable is needed on the accumulator.

## Interface
Parameters:
- DATA_W, 8, width of stream data and of `in` (must match accumulator input width)
- DEPTH, 8, FIFO entries; power of two, ≥ 2

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- s_data  input  DATA_W  upstream word
- s_valid  input  1  upstream word present
- s_ready  output  1  FIFO can accept; = !full && !flush && !rst
- hold  input  1  pause draining (in forced to 0, FIFO retained)
- flush  input  1  synchronous clear of FIFO contents
- in  output  DATA_W  registered word to accumulator `in`
- in_valid  output  1  registered; 1 when `in` carries a popped word
- count  output  $clog2(DEPTH)+1  words currently stored
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: circular buffer, write pointer and read pointer of $clog2(DEPTH) bits, each wrapping DEPTH-1 → 0; `count` is a separate register (no pointer-MSB trick).
- Push: s_valid && s_ready at a rising edge writes s_data at the write pointer, and the write pointer increments.
- Pop: at a rising edge with !hold && !flush && !empty, the head word is loaded into `in`, in_valid <= 1, and the read pointer increments.
- No pop: in <= 0, in_valid <= 0.
- No bypass: a word pushed at edge N is never popped at edge N, even if the FIFO was empty.
- count update per edge: +1 push only, −1 pop only, unchanged for both or neither.
- Simultaneous push and pop when full: cannot occur, because s_ready=0 when full. A pop while full frees a slot, and s_ready rises after that edge.
- flush=1 at an edge:
  - pointers and count go to 0, in <= 0, in_valid <= 0;
  - no push or pop occurs;
  - flush wins over s_valid and hold.
- hold=1: FIFO may still accept pushes until full; `in` is zero every cycle hold is sampled high.
- No sticky errors or drops: backpressure is the only overflow mechanism. Upstream must hold s_data/s_valid until accepted.

## Timing
- Reset (async assert, sync-free release): in=0, in_valid=0, count=0, empty=1, full=0, pointers=0. s_ready=0 while rst=1 and 1 in the first cycle after release.
- Latency: word accepted at edge N appears on `in` after edge N+1 at the earliest (1 cycle in FIFO). The accumulator adds it at edge N+2.
- Throughput: one word per clock sustained, with push and pop every cycle and count steady.
- full/empty/count are registered-state derived, valid immediately after each edge. s_ready is combinational from full, flush and rst only (never from s_valid).
- Reset asserted mid-stream: all contents are discarded at once and `in` goes to 0 asynchronously. The accumulator, sharing rst, clears simultaneously.
- Wrap-around: after DEPTH pushes and pops, the pointers return to 0 with no gap in in_valid.

## Test plan
- Reset/idle: rst high 2 cycles, then release, no s_valid → in=0, in_valid=0, empty=1, s_ready=1; accumulator sum stays 0.
- Single word: push 8'h05 at edge N → count=1 after N; in=5, in_valid=1 after N+1; in=0 after N+2; accumulator sum=5.
- Back-pressure: hold=1, push 9 words 1..9 with DEPTH=8 → s_ready=0 after the 8th, full=1, 9th word held by upstream. Release hold → in sequence 1..8 one per cycle, the 9th word accepted during draining, then 9. Sum=45.
- Streaming wrap: 20 consecutive words 3 each cycle, no hold → count stays ≤1, in_valid continuous 20 cycles, pointers wrap twice, sum=60.
- Flush: load 4 words (10,20,30,40), hold=1, pulse flush with s_valid=1 → count=0, empty=1, word not accepted that cycle, in=0. Subsequent push 7 → sum increases by exactly 7.
- Async reset mid-drain: 5 words queued, assert rst between edges during drain → in=0, count=0 immediately (before next edge). After release, no stale word appears on `in`.

Source files
------------

// File: rtl/acc_feeder.sv
// acc_feeder: stream FIFO that drains one word per clock into a registered
// accumulator input; `in` reads zero whenever no word is popped.
module acc_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     hold,
    input  logic                     flush,
    output logic [DATA_W-1:0]        in,
    output logic                     in_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_in;
    logic              r_in_valid;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready never looks at s_valid, so upstream sees no combinational loop.
    assign s_ready = !w_full && !flush && !rst;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = !hold && !flush && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in       <= '0;
            r_in_valid <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in       <= '0;
            r_in_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            // Pop reads the old head; a word written this edge is never bypassed.
            if (w_pop) begin
                r_in       <= r_mem[r_rptr];
                r_in_valid <= 1'b1;
                r_rptr     <= r_rptr + PW'(1);
            end else begin
                r_in       <= '0;
                r_in_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in       = r_in;
    assign in_valid = r_in_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule
